// File: rtl/mac_tx_arbiter.sv
// rtl/mac_tx_arbiter.sv - packet-granular TX arbiter with round-robin/priority grant and beat watchdog
//
// Shares one MAC TX encapsulation datapath between NUM_PORTS byte streams.
// A port is granted for a whole packet; the granted stream is muxed straight
// through to m_* with no added latency. A packet that reaches MAX_BEATS
// without tlast is cut short (last beat flagged tlast+tuser) and the rest of
// it is swallowed so the encapsulator never waits on a runaway source.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   s_tdata/tvalid/tuser/tlast per-port input streams, port i at byte lane i
//   s_tready                   per-port ready (only the granted port is ever ready)
//   m_tdata/tvalid/tuser/tlast stream to the encapsulator
//   m_tready                   ready from the encapsulator
//   grant                      registered one-hot grant, zero when idle
//   trunc                      one-cycle pulse after a truncating beat is accepted
module mac_tx_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int PRIO_PORT0 = 1,
  parameter int MAX_BEATS  = 1514
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS*8-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]   s_tvalid,
  output logic [NUM_PORTS-1:0]   s_tready,
  input  logic [NUM_PORTS-1:0]   s_tuser,
  input  logic [NUM_PORTS-1:0]   s_tlast,
  output logic [7:0]             m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tuser,
  output logic                   m_tlast,
  output logic [NUM_PORTS-1:0]   grant,
  output logic                   trunc
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                 trunc_q, trunc_d;

  // Winner search. cand is one bit wider than a port index so that
  // rr_ptr + k can be wrapped back into range without modulo.
  logic          win_found;
  logic          win_prio;
  logic [PW-1:0] win_idx;
  logic [PW:0]   cand;

  always_comb begin
    win_found = 1'b0;
    win_prio  = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (PRIO_PORT0 != 0 && s_tvalid[0]) begin
      win_found = 1'b1;
      win_prio  = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
        if (cand >= (PW+1)'(NUM_PORTS)) cand = cand - (PW+1)'(NUM_PORTS);
        if (!win_found && s_tvalid[cand[PW-1:0]]) begin
          win_found = 1'b1;
          win_idx   = cand[PW-1:0];
        end
      end
    end
  end

  // Mux of the granted port, keyed by the registered index only.
  logic       g_valid, g_last, g_user;
  logic [7:0] g_data;
  logic       trunc_beat;
  logic [CW-1:0] cnt_inc;

  assign g_valid = s_tvalid[gidx_q];
  assign g_last  = s_tlast[gidx_q];
  assign g_user  = s_tuser[gidx_q];
  assign g_data  = s_tdata[{gidx_q, 3'b000} +: 8];

  // The beat presented with MAX_BEATS-1 already accepted is the last one
  // we let through; if it is not a real tlast it gets forced into one.
  assign trunc_beat = (beat_cnt_q == CW'(MAX_BEATS - 1)) && !g_last;
  assign cnt_inc    = (beat_cnt_q == CW'(MAX_BEATS)) ? beat_cnt_q : beat_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    m_tlast    = 1'b0;
    m_tuser    = 1'b0;
    s_tready   = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d    = NUM_PORTS'(1) << win_idx;
          gidx_d     = win_idx;
          beat_cnt_d = '0;
          state_d    = BUSY;
          // A priority win must not disturb the round-robin order of the rest.
          if (!win_prio) rr_ptr_d = win_idx;
        end
      end
      BUSY: begin
        m_tvalid         = g_valid;
        m_tdata          = g_data;
        m_tlast          = g_last | trunc_beat;
        m_tuser          = g_user | trunc_beat;
        s_tready[gidx_q] = m_tready;
        if (g_valid && m_tready) begin
          beat_cnt_d = cnt_inc;
          if (g_last) begin
            grant_d = '0;
            state_d = IDLE;
          end else if (trunc_beat) begin
            trunc_d = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Swallow the tail of a truncated packet without forwarding it.
        s_tready[gidx_q] = 1'b1;
        if (g_valid) begin
          beat_cnt_d = cnt_inc;
          if (g_last) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= PW'(NUM_PORTS - 1);
      beat_cnt_q <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  assign grant = grant_q;
  assign trunc = trunc_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb/tb_mac_tx_arbiter.sv - self-checking bench for mac_tx_arbiter
module tb_mac_tx_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // DUT A: strict priority for port 0
  logic [31:0] a_s_tdata = '0;
  logic [3:0]  a_s_tvalid = '0, a_s_tuser = '0, a_s_tlast = '0, a_s_tready;
  logic [7:0]  a_m_tdata;
  logic        a_m_tvalid, a_m_tuser, a_m_tlast, a_trunc;
  logic        a_m_tready = 1'b1;
  logic [3:0]  a_grant;

  mac_tx_arbiter #(.NUM_PORTS(4), .PRIO_PORT0(1), .MAX_BEATS(1514)) dut_a (
    .clk(clk), .reset(reset),
    .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready),
    .s_tuser(a_s_tuser), .s_tlast(a_s_tlast),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready),
    .m_tuser(a_m_tuser), .m_tlast(a_m_tlast),
    .grant(a_grant), .trunc(a_trunc)
  );

  // DUT B: pure round robin, fed by four always-valid 3-beat sources
  logic [31:0] b_s_tdata;
  logic [3:0]  b_s_tvalid, b_s_tlast, b_s_tready;
  logic [3:0]  b_s_tuser = '0;
  logic [7:0]  b_m_tdata;
  logic        b_m_tvalid, b_m_tuser, b_m_tlast, b_trunc;
  logic        b_m_tready = 1'b1;
  logic [3:0]  b_grant;
  logic        b_en = 1'b0;
  logic [1:0]  bcnt [4];

  mac_tx_arbiter #(.NUM_PORTS(4), .PRIO_PORT0(0), .MAX_BEATS(1514)) dut_b (
    .clk(clk), .reset(reset),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
    .s_tuser(b_s_tuser), .s_tlast(b_s_tlast),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
    .m_tuser(b_m_tuser), .m_tlast(b_m_tlast),
    .grant(b_grant), .trunc(b_trunc)
  );

  assign b_s_tvalid = {4{b_en}};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) bcnt[i] <= 2'd0;
      else if (b_s_tvalid[i] && b_s_tready[i]) bcnt[i] <= (bcnt[i] == 2'd2) ? 2'd0 : bcnt[i] + 2'd1;
    end
  end

  always_comb begin
    b_s_tlast = '0;
    b_s_tdata = '0;
    for (int i = 0; i < 4; i++) begin
      b_s_tlast[i]       = (bcnt[i] == 2'd2);
      b_s_tdata[i*8 +: 8] = {4'(i), 2'b00, bcnt[i]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Results of the last a_send call
  logic [7:0] out_q[$];
  int last_cnt, last_pos, user_cnt, user_pos, trunc_cnt, trunc_at, drain_cnt, grant_first, cyc_used;

  // Drive one packet of len bytes (byte n = n*7+p) on DUT A port p until
  // stop_at beats have been accepted at the source side, logging what appears on m_*.
  task automatic a_send(input int p, input int len, input bit rnd, input int stop_at);
    int sent;
    sent = 0;
    out_q.delete();
    last_cnt = 0; last_pos = -1; user_cnt = 0; user_pos = -1;
    trunc_cnt = 0; trunc_at = -1; drain_cnt = 0; grant_first = -1; cyc_used = 0;
    while (sent < stop_at && cyc_used < 20000) begin
      @(negedge clk);
      a_s_tvalid = '0;
      a_s_tvalid[p] = 1'b1;
      a_s_tlast = '0;
      a_s_tlast[p] = (sent == len - 1);
      a_s_tuser = '0;
      a_s_tdata[p*8 +: 8] = 8'(sent * 7 + p);
      a_m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (a_trunc) begin trunc_cnt++; trunc_at = sent; end
      if (grant_first < 0 && a_grant == (4'b0001 << p)) grant_first = cyc_used;
      if (a_m_tvalid && a_m_tready) begin
        out_q.push_back(a_m_tdata);
        if (a_m_tlast) begin last_cnt++; last_pos = out_q.size(); end
        if (a_m_tuser) begin user_cnt++; user_pos = out_q.size(); end
      end
      if (a_s_tready[p]) begin
        if (!a_m_tvalid) drain_cnt++;
        sent++;
      end
      cyc_used++;
    end
    chk("send_in_budget", 32'(cyc_used < 20000), 32'd1);
    if (sent >= len) begin
      @(negedge clk);
      a_s_tvalid = '0;
      a_s_tlast = '0;
      a_m_tready = 1'b1;
      #1;
      if (a_trunc) begin trunc_cnt++; trunc_at = sent; end
    end
  endtask

  typedef struct {
    logic [3:0] vld, lst, usr;
    logic       rdy;
    logic [3:0] e_grant;
    logic       e_mv;
    logic [7:0] e_md;
    logic       e_ml, e_mu;
    logic [3:0] e_srdy;
  } vec_t;

  vec_t vt[13];

  initial begin
    int mism;
    logic [3:0] eg;

    //        vld      lst      usr      rdy   grant    mv    md     ml    mu    srdy
    vt[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vt[1]  = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vt[2]  = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'hC2, 1'b0, 1'b0, 4'b0100};
    vt[3]  = '{4'b0101, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'hC2, 1'b0, 1'b0, 4'b0000};
    vt[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'hC2, 1'b0, 1'b0, 4'b0100};
    vt[5]  = '{4'b0101, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hC2, 1'b1, 1'b1, 4'b0100};
    vt[6]  = '{4'b1001, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vt[7]  = '{4'b1001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'hA0, 1'b1, 1'b0, 4'b0001};
    vt[8]  = '{4'b1010, 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vt[9]  = '{4'b1010, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 8'hD3, 1'b1, 1'b0, 4'b1000};
    vt[10] = '{4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000};
    vt[11] = '{4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'hB1, 1'b1, 1'b0, 4'b0010};
    vt[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000};

    // Reset state of both instances
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_a_grant", 32'(a_grant), 0);
    chk("rst_a_mvalid", 32'(a_m_tvalid), 0);
    chk("rst_a_mdata", 32'(a_m_tdata), 0);
    chk("rst_a_mlast_muser", 32'({a_m_tlast, a_m_tuser}), 0);
    chk("rst_a_sready", 32'(a_s_tready), 0);
    chk("rst_a_trunc", 32'(a_trunc), 0);
    chk("rst_b_grant", 32'(b_grant), 0);
    chk("rst_b_mvalid", 32'(b_m_tvalid), 0);
    reset = 1'b0;

    // Table: arbitration, passthrough, stalls, gaps, priority vs round robin
    a_s_tdata = 32'hD3C2B1A0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      a_s_tvalid = vt[i].vld;
      a_s_tlast  = vt[i].lst;
      a_s_tuser  = vt[i].usr;
      a_m_tready = vt[i].rdy;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(a_grant), 32'(vt[i].e_grant));
      chk($sformatf("v%0d_mvalid", i), 32'(a_m_tvalid), 32'(vt[i].e_mv));
      chk($sformatf("v%0d_mdata", i), 32'(a_m_tdata), 32'(vt[i].e_md));
      chk($sformatf("v%0d_mlast", i), 32'(a_m_tlast), 32'(vt[i].e_ml));
      chk($sformatf("v%0d_muser", i), 32'(a_m_tuser), 32'(vt[i].e_mu));
      chk($sformatf("v%0d_sready", i), 32'(a_s_tready), 32'(vt[i].e_srdy));
      chk($sformatf("v%0d_trunc", i), 32'(a_trunc), 0);
    end

    // 60-byte packet on port 2, no backpressure
    a_send(2, 60, 1'b0, 60);
    chk("p2_grant_latency", 32'(grant_first), 1);
    chk("p2_cycles", 32'(cyc_used), 61);
    chk("p2_count", 32'(out_q.size()), 60);
    chk("p2_last_pos", 32'(last_pos), 60);
    chk("p2_last_cnt", 32'(last_cnt), 1);
    chk("p2_trunc_cnt", 32'(trunc_cnt), 0);
    mism = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 8'(i * 7 + 2)) mism++;
    chk("p2_data", 32'(mism), 0);
    chk("p2_grant_after", 32'(a_grant), 0);

    // Ports 0 and 3 both valid with single-beat packets: port 0 starves port 3
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_s_tvalid = (k >= 6) ? 4'b1000 : 4'b1001;
      a_s_tlast  = 4'b1001;
      a_s_tuser  = '0;
      a_m_tready = 1'b1;
      #1;
      eg = (k % 2 == 0) ? 4'b0000 : ((k == 7) ? 4'b1000 : 4'b0001);
      chk($sformatf("prio_k%0d_grant", k), 32'(a_grant), 32'(eg));
    end

    // 2000-byte runaway packet on port 1
    a_send(1, 2000, 1'b0, 2000);
    chk("wd_count", 32'(out_q.size()), 1514);
    chk("wd_last_pos", 32'(last_pos), 1514);
    chk("wd_last_cnt", 32'(last_cnt), 1);
    chk("wd_user_pos", 32'(user_pos), 1514);
    chk("wd_user_cnt", 32'(user_cnt), 1);
    chk("wd_trunc_cnt", 32'(trunc_cnt), 1);
    chk("wd_trunc_at", 32'(trunc_at), 1514);
    chk("wd_drain_cnt", 32'(drain_cnt), 486);
    chk("wd_grant_after", 32'(a_grant), 0);

    // 100 bytes on port 0 under random backpressure
    a_send(0, 100, 1'b1, 100);
    chk("bp_count", 32'(out_q.size()), 100);
    chk("bp_last_pos", 32'(last_pos), 100);
    mism = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 8'(i * 7)) mism++;
    chk("bp_data", 32'(mism), 0);
    chk("bp_trunc_cnt", 32'(trunc_cnt), 0);

    // Reset in the middle of a port 3 packet
    a_send(3, 40, 1'b0, 20);
    chk("rm_count", 32'(out_q.size()), 20);
    @(negedge clk);
    reset = 1'b1;
    a_s_tvalid = 4'b1001;
    a_s_tlast = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rm_grant", 32'(a_grant), 0);
    chk("rm_mvalid", 32'(a_m_tvalid), 0);
    chk("rm_sready", 32'(a_s_tready), 0);
    @(negedge clk); #1;
    chk("rm_regrant", 32'(a_grant), 32'h1);
    a_s_tlast = 4'b0001;
    @(negedge clk);
    a_s_tvalid = '0;
    a_s_tlast = '0;
    #1;
    chk("rm_grant_done", 32'(a_grant), 0);

    // Round robin with all four ports continuously valid, 3-byte packets
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) b_en = 1'b1;
      #1;
      if (c % 4 == 0) begin
        chk($sformatf("rr_c%0d_grant", c), 32'(b_grant), 0);
        chk($sformatf("rr_c%0d_mvalid", c), 32'(b_m_tvalid), 0);
      end else begin
        chk($sformatf("rr_c%0d_grant", c), 32'(b_grant), 32'(4'b0001 << ((c / 4) % 4)));
        chk($sformatf("rr_c%0d_mvalid", c), 32'(b_m_tvalid), 1);
        chk($sformatf("rr_c%0d_mdata", c), 32'(b_m_tdata), 32'({4'((c / 4) % 4), 4'((c % 4) - 1)}));
        chk($sformatf("rr_c%0d_mlast", c), 32'(b_m_tlast), 32'(c % 4 == 3));
      end
    end
    b_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Packet-granular arbiter that shares the single MAC TX frame-encapsulation datapath between NUM_PORTS AXI-stream byte sources, for example host data, pause-frame generator and management. It grants one requester per packet using round-robin order, with optional strict priority for port 0, and passes the granted stream through to the encapsulator with no added latency. A per-packet beat watchdog truncates runaway packets, marks them errored, and drains the remainder of the packet so the encapsulator is never held indefinitely.

## Interface
Parameters:
- NUM_PORTS, default 4: number of requesters; legal range 2..8.
- PRIO_PORT0, default 1: when 1, port 0 wins over all others at every arbitration.
- MAX_BEATS, default 1514: maximum accepted beats per packet, i.e. header plus maximum payload, excluding FCS.

Ports:
- clk  in  1: single clock; all logic on the rising edge.
- reset  in  1: synchronous, active-high reset.
- s_tdata  in  NUM_PORTS*8: requester bytes; port i occupies bits [8i+7:8i].
- s_tvalid  in  NUM_PORTS: per-port valid.
- s_tready  out  NUM_PORTS: per-port ready.
- s_tuser  in  NUM_PORTS: per-port error flag, passed through unchanged.
- s_tlast  in  NUM_PORTS: per-port end of packet.
- m_tdata  out  8: byte to the encapsulator.
- m_tvalid  out  1: valid to the encapsulator.
- m_tready  in  1: ready from the encapsulator.
- m_tuser  out  1: error flag to the encapsulator.
- m_tlast  out  1: end of packet to the encapsulator.
- grant  out  NUM_PORTS: registered one-hot grant; all zero when no port is granted.
- trunc  out  1: registered one-cycle pulse when the watchdog truncates a packet.

## Operation
- State machine states: IDLE, BUSY, DRAIN.
- IDLE
  - m_tvalid=0 and all s_tready=0.
  - If any s_tvalid is set, select the winner, load it into grant, clear beat_cnt, and move to BUSY on the same edge.
  - Selection: if PRIO_PORT0=1 and s_tvalid[0]=1, the winner is port 0. Otherwise search upward from (rr_ptr+1) mod NUM_PORTS and take the first port with tvalid set.
  - rr_ptr is updated to the winner only for a round-robin win, not for a priority win.
- BUSY, with g the granted port
  - m_tdata, m_tuser, m_tlast and m_tvalid follow port g combinationally.
  - s_tready[g]=m_tready; all other s_tready are 0.
- A beat is accepted when m_tvalid and m_tready are both high.
  - Each accepted beat increments beat_cnt. The counter is $clog2(MAX_BEATS+1) bits wide and saturates at MAX_BEATS.
- Accepted beat with s_tlast=1: grant is cleared and the state returns to IDLE.
- Watchdog: the beat being presented while beat_cnt==MAX_BEATS-1 with s_tlast[g]=0 is truncated.
  - It is output with m_tlast=1 and m_tuser=1.
  - On its acceptance, trunc pulses and the state moves to DRAIN.
- DRAIN
  - m_tvalid=0 and s_tready[g]=1; the bytes are discarded.
  - An accepted beat with s_tlast=1 clears grant and returns the state to IDLE.
- A requester's tvalid dropping mid-packet is legal: m_tvalid simply follows it. There is no timeout on idle gaps.
- Requests from non-granted ports are ignored until the next IDLE cycle. Their tvalid may stay high indefinitely.
- Single-beat packet (tlast on the first beat) is legal, giving BUSY for one accepted beat.
- Simultaneous requests
  - PRIO_PORT0=0 and all ports valid: grants cycle 0,1,2,...,NUM_PORTS-1,0.
  - PRIO_PORT0=1: port 0 asserting continuously starves the others, which is intended.
- Reset, including mid-packet:
  - state=IDLE, grant=0, rr_ptr=NUM_PORTS-1 (so the first round-robin winner is port 0), beat_cnt=0, trunc=0.
  - All outputs low: m_tvalid, m_tlast, m_tuser, s_tready; m_tdata=0.
  - A partially forwarded packet is abandoned. The encapsulator is reset alongside and cleans up its side.

## Timing
- Arbitration latency: the first s_tvalid seen in IDLE gives grant and m_tvalid on the next cycle.
- Datapath latency: zero cycles from port g to m_* while in BUSY; the path is combinational through a mux keyed by registered grant.
- Minimum inter-packet gap on m_*: one cycle, namely the IDLE cycle.
- grant updates on the edge that leaves IDLE and on the edge that accepts the final beat.
- trunc is high for exactly the one cycle after the truncating beat is accepted.
- No combinational path from m_tready to m_tvalid. s_tready depends combinationally on m_tready and registered state only.

## Test plan
- Single port 2 sends 60 bytes with m_tready=1: grant=4'b0100 one cycle after tvalid; 60 bytes forwarded contiguously with m_tlast on byte 60; grant returns to 0; trunc never pulses.
- PRIO_PORT0=0, all 4 ports continuously valid, 3-byte packets: grant order 0,1,2,3,0; exactly one idle m_tvalid cycle between packets.
- PRIO_PORT0=1, ports 0 and 3 continuously valid: port 0 is granted for every packet. After port 0 deasserts, port 3 is granted on the next arbitration.
- Port 1 sends a 2000-byte packet with MAX_BEATS=1514: beat 1514 is output with m_tlast=1 and m_tuser=1; trunc pulses once; the remaining 486 bytes are accepted with m_tvalid=0; the state then returns to IDLE.
- Random m_tready backpressure (50%) on 100 bytes from port 0: output byte sequence matches the input exactly; no beat is duplicated or dropped.
- reset asserted mid-packet at byte 20: on the next cycle grant=0, m_tvalid=0 and all s_tready=0; the next arbitration selects port 0.
